// File: rtl/operand_fetch_pkg.sv
// Shared widths and bundle types for the operand-fetch stage.
package of_pkg;
   localparam int DW   = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   typedef struct packed {
      logic       add_sub;
      logic [1:0] logic_fn;
      logic [1:0] fn;
   } alu_ctrl_t;

   typedef struct packed {
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      alu_ctrl_t     ctrl;
      logic [AW-1:0] rd;
      logic          rd_en;
   } op_t;
endpackage

// File: rtl/operand_fetch_if.sv
// Decode, write-back and ALU-side signals of the operand-fetch stage.
interface operand_fetch_if;
   import of_pkg::*;

   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_rs;
   logic [AW-1:0] in_rt;
   logic [AW-1:0] in_rd;
   logic          in_rd_en;
   logic          in_use_imm;
   logic [DW-1:0] in_imm;
   logic          in_add_sub;
   logic [1:0]    in_logic_fn;
   logic [1:0]    in_fn;

   logic          wb_en;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;

   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] x;
   logic [DW-1:0] y;
   logic          add_sub;
   logic [1:0]    logic_fn;
   logic [1:0]    fn;
   logic [AW-1:0] out_rd;
   logic          out_rd_en;

   modport slave (
      input  in_valid, in_rs, in_rt, in_rd, in_rd_en, in_use_imm, in_imm,
             in_add_sub, in_logic_fn, in_fn,
      input  wb_en, wb_addr, wb_data,
      input  out_ready,
      output in_ready,
      output out_valid, x, y, add_sub, logic_fn, fn, out_rd, out_rd_en
   );

   modport master (
      output in_valid, in_rs, in_rt, in_rd, in_rd_en, in_use_imm, in_imm,
             in_add_sub, in_logic_fn, in_fn,
      output wb_en, wb_addr, wb_data,
      output out_ready,
      input  in_ready,
      input  out_valid, x, y, add_sub, logic_fn, fn, out_rd, out_rd_en
   );
endinterface

// File: rtl/operand_fetch_reg_file.sv
// Register file: 2 read / 1 write, R0 hard-zero, same-cycle write-back bypass.
// Reads are combinational; writes and synchronous clear land on the rising clk.
module reg_file #(
   parameter int DW   = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] i_ra_addr,
   output logic [DW-1:0] o_ra_data,
   input  logic [AW-1:0] i_rb_addr,
   output logic [DW-1:0] o_rb_data,
   input  logic          i_we,
   input  logic [AW-1:0] i_wa,
   input  logic [DW-1:0] i_wd
);
   logic [DW-1:0] r_mem [NREG];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else if (i_we && i_wa != '0) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   // Address 0 always wins over the bypass so R0 can never leak a write.
   always_comb begin
      o_ra_data = r_mem[i_ra_addr];
      if (i_ra_addr == '0)                o_ra_data = '0;
      else if (i_we && i_wa == i_ra_addr) o_ra_data = i_wd;
   end

   always_comb begin
      o_rb_data = r_mem[i_rb_addr];
      if (i_rb_addr == '0)                o_rb_data = '0;
      else if (i_we && i_wa == i_rb_addr) o_rb_data = i_wd;
   end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: regfile read + bypass, RAW/WAW scoreboard, registered ALU bundle.
// One cycle accept-to-valid; stalls decode on hazards or when the held bundle is not consumed.
module operand_fetch
   import of_pkg::*;
#(
   parameter int DW   = of_pkg::DW,
   parameter int NREG = of_pkg::NREG,
   parameter int AW   = of_pkg::AW
) (
   input logic            clk,
   input logic            rst_n,
   operand_fetch_if.slave bus
);
   logic [NREG-1:0] r_pending;
   op_t             r_op;
   logic            r_out_vld;

   logic [DW-1:0]   w_rs_data;
   logic [DW-1:0]   w_rt_data;
   logic [NREG-1:0] w_clr;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_pend;
   logic            w_stall;
   logic            w_ready;
   logic            w_accept;
   op_t             w_nxt_op;

   reg_file #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_ra_addr (bus.in_rs),
      .o_ra_data (w_rs_data),
      .i_rb_addr (bus.in_rt),
      .o_rb_data (w_rt_data),
      .i_we      (bus.wb_en),
      .i_wa      (bus.wb_addr),
      .i_wd      (bus.wb_data)
   );

   // w_pend is the scoreboard as seen after this cycle's write-back retires.
   always_comb begin
      w_clr = '0;
      if (bus.wb_en && bus.wb_addr != '0) w_clr[bus.wb_addr] = 1'b1;
      w_pend = r_pending & ~w_clr;
   end

   assign w_stall  = w_pend[bus.in_rs]
                   | (!bus.in_use_imm & w_pend[bus.in_rt])
                   | (bus.in_rd_en & w_pend[bus.in_rd]);
   assign w_ready  = !w_stall && (!r_out_vld || bus.out_ready);
   assign w_accept = bus.in_valid && w_ready;

   always_comb begin
      w_set = '0;
      if (w_accept && bus.in_rd_en && bus.in_rd != '0) w_set[bus.in_rd] = 1'b1;
   end

   always_comb begin
      w_nxt_op               = '0;
      w_nxt_op.x             = w_rs_data;
      w_nxt_op.y             = bus.in_use_imm ? bus.in_imm : w_rt_data;
      w_nxt_op.ctrl.add_sub  = bus.in_add_sub;
      w_nxt_op.ctrl.logic_fn = bus.in_logic_fn;
      w_nxt_op.ctrl.fn       = bus.in_fn;
      w_nxt_op.rd            = bus.in_rd;
      w_nxt_op.rd_en         = bus.in_rd_en;
   end

   // OR-ing the set after the clear lets a new claim win over the older write-back.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pend | w_set;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op      <= '0;
         r_out_vld <= 1'b0;
      end else if (w_accept) begin
         r_op      <= w_nxt_op;
         r_out_vld <= 1'b1;
      end else if (bus.out_ready) begin
         r_out_vld <= 1'b0;
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_valid = r_out_vld;
   assign bus.x         = r_op.x;
   assign bus.y         = r_op.y;
   assign bus.add_sub   = r_op.ctrl.add_sub;
   assign bus.logic_fn  = r_op.ctrl.logic_fn;
   assign bus.fn        = r_op.ctrl.fn;
   assign bus.out_rd    = r_op.rd;
   assign bus.out_rd_en = r_op.rd_en;
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed issue/write-back vectors, monitor checks the ALU bundle.
module tb_operand_fetch;
   import of_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   op_t  exp_q[$];

   operand_fetch_if bus();

   operand_fetch dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] addr, input logic [31:0] data);
      bus.wb_en   = 1'b1;
      bus.wb_addr = addr;
      bus.wb_data = data;
      step();
      bus.wb_en   = 1'b0;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic rd_en, input logic use_imm, input logic [31:0] imm,
                        input logic [4:0] ctl);
      bus.in_rs       = rs;
      bus.in_rt       = rt;
      bus.in_rd       = rd;
      bus.in_rd_en    = rd_en;
      bus.in_use_imm  = use_imm;
      bus.in_imm      = imm;
      bus.in_add_sub  = ctl[4];
      bus.in_logic_fn = ctl[3:2];
      bus.in_fn       = ctl[1:0];
      bus.in_valid    = 1'b1;
   endtask

   function automatic op_t mk(input logic [31:0] ex, input logic [31:0] ey, input logic [4:0] ctl,
                              input logic [4:0] rd, input logic rd_en);
      op_t e;
      e.x             = ex;
      e.y             = ey;
      e.ctrl.add_sub  = ctl[4];
      e.ctrl.logic_fn = ctl[3:2];
      e.ctrl.fn       = ctl[1:0];
      e.rd            = rd;
      e.rd_en         = rd_en;
      return e;
   endfunction

   // Issue one instruction and wait (bounded) for it to be accepted.
   task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic rd_en, input logic use_imm, input logic [31:0] imm,
                       input logic [4:0] ctl, input logic [31:0] ex, input logic [31:0] ey,
                       input int budget);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      drive(rs, rt, rd, rd_en, use_imm, imm, ctl);
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(mk(ex, ey, ctl, rd, rd_en));
            done = 1'b1;
         end else if (n >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: rs=%0d rd=%0d not accepted after %0d stalled cycles", rs, rd, n + 1);
            done = 1'b1;
         end else begin
            n++;
            step();
         end
      end
      step();
      bus.in_valid = 1'b0;
   endtask

   initial begin : monitor
      op_t a;
      op_t e;
      op_t snap;
      bit  stalled;
      stalled = 1'b0;
      snap    = '0;
      forever begin
         @(negedge clk);
         a.x             = bus.x;
         a.y             = bus.y;
         a.ctrl.add_sub  = bus.add_sub;
         a.ctrl.logic_fn = bus.logic_fn;
         a.ctrl.fn       = bus.fn;
         a.rd            = bus.out_rd;
         a.rd_en         = bus.out_rd_en;
         if (stalled && bus.out_valid) check("hold_stable", a, snap);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: x=%0h y=%0h rd=%0d, required no bundle", a.x, a.y, a.rd);
            end else begin
               e = exp_q.pop_front();
               check("out_x", a.x, e.x);
               check("out_y", a.y, e.y);
               check("out_ctl_rd", {a.ctrl, a.rd, a.rd_en}, {e.ctrl, e.rd, e.rd_en});
            end
         end
         stalled = bus.out_valid && !bus.out_ready;
         snap    = a;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] bp_imm [4];
      bp_imm[0] = 32'hA0A0_0001;
      bp_imm[1] = 32'hB0B0_0002;
      bp_imm[2] = 32'hC0C0_0003;
      bp_imm[3] = 32'hD0D0_0004;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.out_ready = 1'b1;
      bus.wb_en     = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_data   = '0;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0);
      bus.in_valid  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_xy", {bus.x, bus.y}, 64'h0);
      check("rst_ctl_rd", {bus.add_sub, bus.logic_fn, bus.fn, bus.out_rd, bus.out_rd_en}, 11'h0);
      check("rst_pending", dut.r_pending, 32'h0);
      check("rst_in_ready", bus.in_ready, 1'b1);

      // Independent issue after write-backs
      wb(5'd1, 32'd5);
      wb(5'd2, 32'd7);
      send(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h0, 5'b1_01_10, 32'd5, 32'd7, 0);
      check("t1_pend3", dut.r_pending[3], 1'b1);

      // RAW stall resolved by same-cycle bypass
      drive(5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, 5'b0_11_01);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("raw_stall", bus.in_ready, 1'b0);
         step();
      end
      bus.wb_en   = 1'b1;
      bus.wb_addr = 5'd3;
      bus.wb_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("raw_bypass_rdy", bus.in_ready, 1'b1);
      if (bus.in_ready) exp_q.push_back(mk(32'hDEAD_BEEF, 32'h0, 5'b0_11_01, 5'd6, 1'b1));
      step();
      bus.in_valid = 1'b0;
      bus.wb_en    = 1'b0;
      check("raw_pending", dut.r_pending, 32'h0000_0040);

      // R0 write ignored; immediate replaces a pending rt without stalling
      wb(5'd0, 32'd9);
      check("r0_no_pend", dut.r_pending, 32'h0000_0040);
      send(5'd0, 5'd6, 5'd7, 1'b0, 1'b1, 32'hFFFF_FFF0, 5'b0_00_11, 32'h0, 32'hFFFF_FFF0, 0);
      wb(5'd6, 32'h66);

      // Set-wins race on R4
      send(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 32'h44, 5'b1_10_00, 32'h0, 32'h44, 0);
      check("race_pre_pend4", dut.r_pending[4], 1'b1);
      drive(5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 32'h0, 5'b0_01_00);
      bus.wb_en   = 1'b1;
      bus.wb_addr = 5'd4;
      bus.wb_data = 32'h1234;
      @(negedge clk);
      check("race_rdy", bus.in_ready, 1'b1);
      if (bus.in_ready) exp_q.push_back(mk(32'd5, 32'd7, 5'b0_01_00, 5'd4, 1'b1));
      step();
      bus.in_valid = 1'b0;
      bus.wb_en    = 1'b0;
      check("race_set_wins", dut.r_pending[4], 1'b1);
      wb(5'd4, 32'h4444);
      check("race_cleared", dut.r_pending, 32'h0);
      send(5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0, 5'd0, 32'h4444, 32'h0, 0);

      // Backpressure: one bundle held, next instruction blocked, then full rate
      step();
      bus.out_ready = 1'b0;
      send(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, bp_imm[0], 5'b1_00_01, 32'd5, bp_imm[0], 0);
      drive(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, bp_imm[1], 5'b1_00_01);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_stall", bus.in_ready, 1'b0);
         step();
      end
      bus.out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         drive(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, bp_imm[k], 5'b1_00_01);
         @(negedge clk);
         check("bp_accept", bus.in_ready, 1'b1);
         if (bus.in_ready) exp_q.push_back(mk(32'd5, bp_imm[k], 5'b1_00_01, 5'd0, 1'b0));
         step();
      end
      bus.in_valid = 1'b0;
      step();

      // Mid-operation reset with a held bundle and pending R5
      wb(5'd5, 32'h55);
      bus.out_ready = 1'b0;
      send(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'hAA, 5'b0_10_10, 32'd5, 32'hAA, 0);
      check("mrst_pre_vld", bus.out_valid, 1'b1);
      check("mrst_pre_pend5", dut.r_pending[5], 1'b1);
      rst_n = 1'b0;
      exp_q.delete();
      step();
      rst_n = 1'b1;
      check("mrst_out_valid", bus.out_valid, 1'b0);
      check("mrst_pending", dut.r_pending, 32'h0);
      check("mrst_x", bus.x, 32'h0);
      bus.out_ready = 1'b1;
      send(5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0, 5'd0, 32'h0, 32'h0, 0);

      repeat (3) step();
      check("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
